// File: rtl/blink_rstgen.sv
// ---------------------------------------------------------------------------
// blink_rstgen
//   Reset sequencer and tick prescaler for the blink counter on the Lowe board.
//   It synchronizes the PLL lock flag and holds blink in reset until lock has
//   been stable for HOLD_CYCLES clocks. After release it emits a one-cycle
//   count-enable strobe every DIV clocks. Losing lock re-asserts reset.
//
//   Optional feature macro: BLINK_RSTGEN_LOSSCNT_EN
//     defined   - loss_cnt counts lock-loss events seen in RUN and saturates
//                 at its maximum value
//     undefined - loss_cnt is tied to 0 and no counter is built
//
// Parameters
//   HOLD_CYCLES  consecutive locked cycles required before release (>=1)
//   DIV          tick period in clk cycles (>=1)
//   CNT_W        lock-loss counter width
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   async active-low reset
//   pll_locked  in   PLL lock flag, asynchronous to clk
//   sys_rst_n   out  registered active-low reset to blink
//   tick        out  registered one-cycle count-enable strobe
//   state       out  FSM state (0 WAIT_LOCK, 1 HOLD, 2 RUN)
//   loss_cnt    out  saturating lock-loss count
// ---------------------------------------------------------------------------
module blink_rstgen #(
    parameter int HOLD_CYCLES = 16,
    parameter int DIV         = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pll_locked,
    output logic             sys_rst_n,
    output logic             tick,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] loss_cnt
);

    // Sized one larger than strictly needed so that no legal parameter
    // value can make a counter wrap.
    localparam int HC_W = $clog2(HOLD_CYCLES + 1);
    localparam int DC_W = $clog2(DIV + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [DC_W-1:0] DIV_LAST  = DC_W'(DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2,
        ILLEGAL   = 2'd3
    } state_t;

    state_t          st;
    logic [1:0]      sync_pipe;
    logic            locked_s;
    logic [HC_W-1:0] hold_cnt;
    logic [DC_W-1:0] div_cnt;

    // Two-flop synchronizer for the asynchronous lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[0], pll_locked};
    end
    assign locked_s = sync_pipe[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= WAIT_LOCK;
            hold_cnt  <= '0;
            div_cnt   <= '0;
            sys_rst_n <= 1'b0;
            tick      <= 1'b0;
        end else begin
            case (st)
                WAIT_LOCK: begin
                    sys_rst_n <= 1'b0;
                    tick      <= 1'b0;
                    hold_cnt  <= '0;
                    div_cnt   <= '0;
                    if (locked_s) st <= HOLD;
                end
                HOLD: begin
                    tick    <= 1'b0;
                    div_cnt <= '0;
                    // Loss wins over completion on the same edge.
                    if (!locked_s) begin
                        st        <= WAIT_LOCK;
                        hold_cnt  <= '0;
                        sys_rst_n <= 1'b0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        st        <= RUN;
                        hold_cnt  <= '0;
                        sys_rst_n <= 1'b1;
                    end else begin
                        hold_cnt  <= hold_cnt + HC_W'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        // Loss also suppresses a tick due on this edge.
                        st        <= WAIT_LOCK;
                        sys_rst_n <= 1'b0;
                        tick      <= 1'b0;
                        div_cnt   <= '0;
                    end else begin
                        sys_rst_n <= 1'b1;
                        // With DIV=1, DIV_LAST is 0 so tick stays high.
                        if (div_cnt == DIV_LAST) begin
                            div_cnt <= '0;
                            tick    <= 1'b1;
                        end else begin
                            div_cnt <= div_cnt + DC_W'(1);
                            tick    <= 1'b0;
                        end
                    end
                end
                default: begin
                    st        <= WAIT_LOCK;
                    hold_cnt  <= '0;
                    div_cnt   <= '0;
                    sys_rst_n <= 1'b0;
                    tick      <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

`ifdef BLINK_RSTGEN_LOSSCNT_EN
    logic run_loss;
    assign run_loss = (st == RUN) && !locked_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            loss_cnt <= '0;
        else if (run_loss && (loss_cnt != {CNT_W{1'b1}}))
            loss_cnt <= loss_cnt + CNT_W'(1);
    end
`else
    assign loss_cnt = '0;
`endif

endmodule

// File: tb/tb_blink_rstgen.sv
// ---------------------------------------------------------------------------
// tb_blink_rstgen
//   Directed bench for blink_rstgen. Instance a uses default parameters,
//   instance b uses HOLD_CYCLES=1, DIV=1, CNT_W=2. Edge numbers count rising
//   clk edges after rst_n release (edge 1 is the first). Inputs change and
//   outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_blink_rstgen;

`ifdef BLINK_RSTGEN_LOSSCNT_EN
    localparam int LOSS_ON = 1;
`else
    localparam int LOSS_ON = 0;
`endif

    logic       clk;
    logic       rst_a, lk_a, rst_b, lk_b;
    logic       srst_a, tick_a, srst_b, tick_b;
    logic [1:0] st_a, st_b;
    logic [3:0] loss_a;
    logic [1:0] loss_b;

    int n_vec = 0;
    int n_err = 0;
    int e     = 0;

    blink_rstgen u_a (
        .clk        (clk),
        .rst_n      (rst_a),
        .pll_locked (lk_a),
        .sys_rst_n  (srst_a),
        .tick       (tick_a),
        .state      (st_a),
        .loss_cnt   (loss_a)
    );

    blink_rstgen #(.HOLD_CYCLES(1), .DIV(1), .CNT_W(2)) u_b (
        .clk        (clk),
        .rst_n      (rst_b),
        .pll_locked (lk_b),
        .sys_rst_n  (srst_b),
        .tick       (tick_b),
        .state      (st_b),
        .loss_cnt   (loss_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    initial begin
        rst_a = 1'b0; lk_a = 1'b1;
        rst_b = 1'b0; lk_b = 1'b1;

        // Power-up reset on instance a
        step(5);
        chk("a_rst_srst",  srst_a, 0);
        chk("a_rst_tick",  tick_a, 0);
        chk("a_rst_state", st_a,   0);
        chk("a_rst_loss",  loss_a, 0);

        // Release; next edge is edge 1
        rst_a = 1'b1;
        e = 0;
        while (e < 43) begin
            step(1);
            if (e == 2)  chk("a_st_e2",  st_a, 0);
            if (e == 3)  chk("a_st_e3",  st_a, 1);
            if (e == 18) begin
                chk("a_srst_e18", srst_a, 0);
                chk("a_st_e18",   st_a,   1);
            end
            if (e == 19) begin
                chk("a_srst_e19", srst_a, 1);
                chk("a_st_e19",   st_a,   2);
                chk("a_tick_e19", tick_a, 0);
            end
            if (e == 22) chk("a_tick_e22", tick_a, 0);
            if (e == 23) chk("a_tick_e23", tick_a, 1);
            if (e == 24) chk("a_tick_e24", tick_a, 0);
            if (e == 27) chk("a_tick_e27", tick_a, 1);
            if (e == 31) chk("a_tick_e31", tick_a, 1);
            if (e == 39) chk("a_tick_e39", tick_a, 1);
            if (e == 40) lk_a = 1'b0;
            if (e == 42) begin
                chk("a_srst_e42", srst_a, 1);
                chk("a_tick_e42", tick_a, 0);
            end
            if (e == 43) begin
                // 43 would have been a tick edge; loss suppresses it
                chk("a_srst_e43", srst_a, 0);
                chk("a_tick_e43", tick_a, 0);
                chk("a_st_e43",   st_a,   0);
                chk("a_loss_e43", loss_a, LOSS_ON);
            end
        end

        // HOLD abort sequence after a fresh reset
        rst_a = 1'b0;
        lk_a  = 1'b1;
        step(2);
        chk("a_rst2_loss",  loss_a, 0);
        chk("a_rst2_state", st_a,   0);
        rst_a = 1'b1;
        e = 0;
        while (e < 60) begin
            step(1);
            if (e == 10) lk_a = 1'b0;
            if (e == 12) chk("ab_st_e12", st_a, 1);
            if (e == 13) begin
                chk("ab_st_e13",   st_a,   0);
                chk("ab_loss_e13", loss_a, 0);
                lk_a = 1'b1;
            end
            if (e == 15) chk("ab_st_e15", st_a, 0);
            if (e == 16) chk("ab_st_e16", st_a, 1);
            if (e == 31) begin
                chk("ab_srst_e31", srst_a, 0);
                chk("ab_st_e31",   st_a,   1);
            end
            if (e == 32) begin
                chk("ab_srst_e32", srst_a, 1);
                chk("ab_st_e32",   st_a,   2);
            end
            if (e == 36) lk_a = 1'b0;
            if (e == 39) begin
                chk("ar_srst_e39", srst_a, 0);
                chk("ar_st_e39",   st_a,   0);
                chk("ar_loss_e39", loss_a, LOSS_ON);
                lk_a = 1'b1;
            end
            if (e == 42) chk("ar_st_e42", st_a, 1);
            if (e == 58) begin
                chk("ar_srst_e58", srst_a, 1);
                chk("ar_st_e58",   st_a,   2);
            end
        end
        chk("a_pre_mid_loss", loss_a, LOSS_ON);

        // Asynchronous reset between edges while in RUN
        #3;
        rst_a = 1'b0;
        #1;
        chk("a_mid_srst",  srst_a, 0);
        chk("a_mid_tick",  tick_a, 0);
        chk("a_mid_state", st_a,   0);
        chk("a_mid_loss",  loss_a, 0);

        // Instance b: HOLD_CYCLES=1, DIV=1, CNT_W=2
        step(1);
        chk("b_rst_srst",  srst_b, 0);
        chk("b_rst_tick",  tick_b, 0);
        chk("b_rst_state", st_b,   0);
        chk("b_rst_loss",  loss_b, 0);
        rst_b = 1'b1;
        e = 0;
        while (e < 10) begin
            step(1);
            if (e == 3) chk("b_st_e3", st_b, 1);
            if (e == 4) begin
                chk("b_srst_e4", srst_b, 1);
                chk("b_st_e4",   st_b,   2);
                chk("b_tick_e4", tick_b, 0);
            end
            if (e >= 5) chk("b_tick_run", tick_b, 1);
        end

        // Five 2-cycle lock drops; count saturates at 3
        for (int i = 1; i <= 5; i++) begin
            lk_b = 1'b0;
            step(2);
            lk_b = 1'b1;
            step(1);
            chk("b_loss_st",   st_b,   0);
            chk("b_loss_srst", srst_b, 0);
            chk("b_loss_tick", tick_b, 0);
            chk("b_loss_cnt",  loss_b, ((i > 3) ? 3 : i) * LOSS_ON);
            step(3);
            chk("b_relock_st", st_b, 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/blink_rstgen.md
# blink_rstgen

Reset sequencer and tick prescaler that sits directly upstream of the `blink` counter on the Lowe board. It qualifies the CC_PLL lock indication against the board reset and holds `blink` in reset until lock has been stable for a programmable interval. Once released, it issues a one-cycle count-enable strobe every `DIV` clocks. If lock is lost, it re-asserts reset and, optionally, counts the loss events for debug on a PMOD header.

## Interface
- `HOLD_CYCLES`, 16: number of consecutive locked cycles required before reset release; legal range ≥1.
- `DIV`, 4: tick period in `clk` cycles; legal range ≥1.
- `CNT_W`, 4: width of the lock-loss counter.

Ports:
- `clk` in 1: single clock (CC_PLL `CLK0`); all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset; it asserts immediately and is released on a clock edge.
- `pll_locked` in 1: CC_PLL `USR_PLL_LOCKED`, asynchronous to `clk`.
- `sys_rst_n` out 1: active-low reset to `blink`, registered.
- `tick` out 1: one-cycle count-enable strobe, registered.
- `state` out 2: current FSM state, for debug.
- `loss_cnt` out `CNT_W`: saturating lock-loss count.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `locked_s`. The synchronizer resets to 0.
- FSM states and encodings: WAIT_LOCK=2'd0, HOLD=2'd1, RUN=2'd2. Code 2'd3 is illegal and returns to WAIT_LOCK on the next edge.
- WAIT_LOCK: `sys_rst_n`=0, `tick`=0, `hold_cnt`=0. When `locked_s`=1, go to HOLD.
- HOLD:
  - When `locked_s`=0: return to WAIT_LOCK and clear `hold_cnt`. `loss_cnt` does not change.
  - Otherwise, when `hold_cnt`=HOLD_CYCLES-1: go to RUN and set `sys_rst_n` to 1 on the same edge.
  - Otherwise: increment `hold_cnt`.
- RUN:
  - `div_cnt` counts 0..DIV-1 and wraps.
  - `tick` is registered high on the edge where `div_cnt` wraps from DIV-1 to 0. It is therefore high for exactly 1 of every DIV cycles.
  - When DIV=1, `tick` is constantly 1 while in RUN.
- Lock loss in RUN (`locked_s`=0):
  - On the next edge: state becomes WAIT_LOCK, `sys_rst_n`=0, `tick`=0, `div_cnt`=0.
  - `loss_cnt` increments and saturates at 2^CNT_W-1.
- Reset values of every output under `rst_n`=0: `sys_rst_n`=0, `tick`=0, `state`=2'd0, `loss_cnt`=0.
- Reset mid-operation: all state clears asynchronously in any state. `loss_cnt` does not increment on `rst_n` assertion.
- Counter widths: `hold_cnt` is $clog2(HOLD_CYCLES+1) bits. `div_cnt` is $clog2(DIV+1) bits. No counter may overflow for any legal parameter value.

## Timing
- Latency from `pll_locked` rising to `locked_s`: 2 edges.
- Reset release sequence, with `rst_n` released before edge 1 and `pll_locked` held at 1:
  - Edge 2: `locked_s`=1.
  - Edge 3: state enters HOLD.
  - Edge 3+HOLD_CYCLES: state enters RUN and `sys_rst_n` rises. With the defaults this is edge 19.
- First `tick` rises at edge 3+HOLD_CYCLES+DIV, which is edge 23 with the defaults. Subsequent ticks follow every DIV edges.
- Lock-loss latency: `pll_locked` falling to `sys_rst_n` falling takes 3 edges (2 for synchronization, 1 for the register).
- A lock glitch shorter than one clock may be missed. A glitch lasting ≥2 clocks is always caught.
- Simultaneous events on the same edge:
  - `locked_s` falls on the HOLD-completion edge: loss takes priority; the FSM goes to WAIT_LOCK and `sys_rst_n` stays 0.
  - `locked_s` falls on a tick edge: `tick` is 0.

## Configuration
- `BLINK_RSTGEN_LOSSCNT_EN`
  - Defined: `loss_cnt` is implemented as described above.
  - Undefined: `loss_cnt` is tied to 0, and no counter logic is synthesized. All other behaviour is identical.

## Test plan
- Power-up: hold `rst_n`=0 for 5 cycles with `pll_locked`=1, then release. Required: all outputs are 0 during reset, `sys_rst_n` rises at edge 19, first `tick` at edge 23, then ticks at edges 27, 31, and so on.
- HOLD abort: drop `pll_locked` for 3 cycles at edge 10. Required: state returns to 0, `loss_cnt` stays 0, and `sys_rst_n` rises 16 cycles after re-synchronized lock.
- RUN lock loss: drop `pll_locked` at edge 40. Required: `sys_rst_n`=0 and `tick`=0 at edge 43, and `loss_cnt`=1.
- Saturation: with CNT_W=2, apply 5 loss events. Required: `loss_cnt`=3. With the macro undefined, `loss_cnt`=0 throughout.
- DIV=1, HOLD_CYCLES=1: `sys_rst_n` rises at edge 4 and `tick` is constantly 1 from edge 5 onward.
- Mid-RUN reset: pulse `rst_n` low asynchronously between edges. Required: outputs clear immediately and `loss_cnt` returns to 0.
